// File: rtl/row_col_dec.sv
// Inverse of the DCO capacitor-bank row/column coder: rebuilds the tuning word from
// r_all/row/col by scanning one index per cycle, and flags illegal select patterns.
module row_col_dec #(
   parameter int WORD_W = 8,
   parameter int ROW_W  = 4,
   parameter int SIZE   = 1 << ROW_W,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [SIZE-1:0]   r_all,
   input  logic [SIZE-1:0]   row,
   input  logic [SIZE-1:0]   col,
   output logic              busy,
   output logic              valid,
   output logic [WORD_W-1:0] word,
   output logic              err,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [1:0]        dbg_state
);

   // Handshake: en is a start request honoured only in IDLE (never queued); valid is a
   // one-cycle completion pulse with no backpressure, word/err/err_cnt are stable outside it.
   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

   localparam int CW = ROW_W + 1;
   localparam logic [CW-1:0] SIZE_C = CW'(SIZE);

   state_t              state_q;
   logic [SIZE-1:0]     ra_q, row_q, col_q;
   logic [ROW_W-1:0]    idx_q;
   logic [CW-1:0]       zcnt_q, ccnt_q, ridx_q;
   logic [1:0]          rcnt_q;
   logic                one_seen_q, therm_bad_q, rise_q, fall_q;
   logic                busy_q, valid_q, err_q;
   logic [WORD_W-1:0]   word_q;
   logic [CNT_W-1:0]    err_cnt_q;

   logic                ra_bit, row_bit, col_bit, col_prev, is_last, r_odd, dec_err;
   logic [SIZE-1:0]     col_prev_vec;
   logic [WORD_W-1:0]   dec_word;

   always_comb begin
      ra_bit       = ra_q[idx_q];
      row_bit      = row_q[idx_q];
      col_bit      = col_q[idx_q];
      col_prev_vec = {col_q[SIZE-2:0], 1'b0};
      col_prev     = col_prev_vec[idx_q];
      is_last      = (idx_q == ROW_W'(SIZE - 1));
      r_odd        = zcnt_q[0];
      // Even rows fill columns upward (no 0->1 step), odd rows downward (no 1->0 step).
      dec_err      = therm_bad_q | (zcnt_q == SIZE_C) | (rcnt_q != 2'd1) |
                     (ridx_q != zcnt_q) | (ccnt_q == SIZE_C) |
                     (!r_odd & rise_q) | (r_odd & fall_q);
      dec_word     = WORD_W'({zcnt_q[ROW_W-1:0], ccnt_q[ROW_W-1:0]});
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         ra_q        <= '0;
         row_q       <= '0;
         col_q       <= '0;
         idx_q       <= '0;
         zcnt_q      <= '0;
         ccnt_q      <= '0;
         ridx_q      <= '0;
         rcnt_q      <= '0;
         one_seen_q  <= 1'b0;
         therm_bad_q <= 1'b0;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         word_q      <= WORD_W'(1) << (WORD_W - 1);
         err_cnt_q   <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (en) begin
                  ra_q        <= r_all;
                  row_q       <= row;
                  col_q       <= col;
                  idx_q       <= '0;
                  zcnt_q      <= '0;
                  ccnt_q      <= '0;
                  ridx_q      <= '0;
                  rcnt_q      <= '0;
                  one_seen_q  <= 1'b0;
                  therm_bad_q <= 1'b0;
                  rise_q      <= 1'b0;
                  fall_q      <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= SCAN;
               end
            end
            SCAN: begin
               if (!ra_bit) zcnt_q <= zcnt_q + 1'b1;
               if (!ra_bit && one_seen_q) therm_bad_q <= 1'b1;
               if (ra_bit) one_seen_q <= 1'b1;
               if (row_bit) begin
                  if (rcnt_q != 2'd2) rcnt_q <= rcnt_q + 1'b1;
                  ridx_q <= {1'b0, idx_q};
               end
               if (col_bit) ccnt_q <= ccnt_q + 1'b1;
               if (col_bit && !col_prev && (idx_q != '0)) rise_q <= 1'b1;
               if (!col_bit && col_prev) fall_q <= 1'b1;
               idx_q <= idx_q + 1'b1;
               if (is_last) state_q <= DONE;
            end
            DONE: begin
               err_q <= dec_err;
               if (!dec_err) word_q <= dec_word;
               else if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
               valid_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign valid     = valid_q;
   assign word      = word_q;
   assign err       = err_q;
   assign err_cnt   = err_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_row_col_dec.sv
// Bench for row_col_dec: reference coder model, per-cycle output compare, directed vectors.
module tb_row_col_dec;

   localparam int SIZE = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en  = 1'b0;
   logic [15:0] r_all = '0, row = '0, col = '0;
   logic        busy, valid, err, busy2, valid2, err2;
   logic [7:0]  word, word2, err_cnt;
   logic [1:0]  err_cnt2, dbg_state, dbg_state2;

   row_col_dec dut (
      .clk(clk), .rst(rst), .en(en), .r_all(r_all), .row(row), .col(col),
      .busy(busy), .valid(valid), .word(word), .err(err), .err_cnt(err_cnt),
      .dbg_state(dbg_state)
   );

   row_col_dec #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .r_all(r_all), .row(row), .col(col),
      .busy(busy2), .valid(valid2), .word(word2), .err(err2), .err_cnt(err_cnt2),
      .dbg_state(dbg_state2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference coder: word -> bank select vectors.
   function automatic void encode(input int w, output logic [15:0] ra, output logic [15:0] rw,
                                  output logic [15:0] cl);
      int r, c;
      r = w / SIZE;
      c = w % SIZE;
      for (int i = 0; i < SIZE; i++) begin
         ra[i] = (i >= r);
         rw[i] = (i == r);
         cl[i] = (r % 2 == 0) ? (i < c) : (i >= SIZE - c);
      end
   endfunction

   // A pattern is legal exactly when some word encodes to it.
   function automatic void ref_decode(input logic [15:0] ra, input logic [15:0] rw,
                                      input logic [15:0] cl, output logic ok, output logic [7:0] w);
      logic [15:0] a, b, c;
      ok = 1'b0;
      w  = '0;
      for (int v = 0; v < 256; v++) begin
         encode(v, a, b, c);
         if (a == ra && b == rw && c == cl) begin
            ok = 1'b1;
            w  = 8'(v);
         end
      end
   endfunction

   typedef struct {
      logic [7:0] word;
      logic       err;
      logic [7:0] cnt;
      logic [1:0] cnt2;
      int         due;
   } exp_t;
   exp_t exp_q[$];

   logic [7:0] m_word = 8'h80;
   logic       m_err  = 1'b0;
   logic [7:0] m_cnt  = '0;
   logic [1:0] m_cnt2 = '0;

   task automatic push_exp(input logic ok, input logic [7:0] w, input int due);
      if (ok) m_word = w;
      else begin
         if (m_cnt != 8'hFF) m_cnt = m_cnt + 1'b1;
         if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 1'b1;
      end
      m_err = !ok;
      exp_q.push_back('{m_word, m_err, m_cnt, m_cnt2, due});
   endtask

   // Compare process: outputs must always equal the last expected result.
   logic [7:0] cur_word = 8'h80, cur_cnt = '0;
   logic       cur_err = 1'b0;
   logic [1:0] cur_cnt2 = '0;
   exp_t       e;

   always @(negedge clk) begin
      if (!rst) begin
         cur_word = 8'h80;
         cur_err  = 1'b0;
         cur_cnt  = '0;
         cur_cnt2 = '0;
         check("rst_busy", busy, 0);
         check("rst_valid", valid, 0);
         check("rst_word", word, 8'h80);
         check("rst_err_cnt", err_cnt, 0);
      end else begin
         if (valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_valid: actual=1 required=0 (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               check("latency", cyc, e.due);
               cur_word = e.word;
               cur_err  = e.err;
               cur_cnt  = e.cnt;
               cur_cnt2 = e.cnt2;
            end
         end
         check("word", word, cur_word);
         check("err", err, cur_err);
         check("err_cnt", err_cnt, cur_cnt);
         check("err_cnt2", err_cnt2, cur_cnt2);
      end
   end

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 80) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_err++;
         $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic run_decode(input logic [15:0] ra, input logic [15:0] rw, input logic [15:0] cl,
                             input bit scramble);
      logic       ok;
      logic [7:0] w;
      int         k;
      @(negedge clk);
      r_all = ra;
      row   = rw;
      col   = cl;
      en    = 1'b1;
      @(posedge clk);
      #1;
      k  = cyc;
      en = 1'b0;
      check("busy_start", busy, 1);
      if (scramble) begin
         r_all = ~ra;
         row   = ~rw;
         col   = 16'h5A5A;
      end
      ref_decode(ra, rw, cl, ok, w);
      push_exp(ok, w, k + 17);
      drain();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] a, b, c;
      logic        ok;
      logic [7:0]  w;
      int          k;

      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Model pins against hand-computed literals.
      ref_decode(16'hFF00, 16'h0100, 16'h0000, ok, w);
      check("pin_model_80", {ok, w}, {1'b1, 8'h80});
      ref_decode(16'hFFFC, 16'h0004, 16'h001F, ok, w);
      check("pin_model_25", {ok, w}, {1'b1, 8'h25});
      ref_decode(16'hFFF8, 16'h0008, 16'hFE00, ok, w);
      check("pin_model_37", {ok, w}, {1'b1, 8'h37});
      ref_decode(16'hFFF8, 16'h0008, 16'h007F, ok, w);
      check("pin_model_dir", ok, 0);

      run_decode(16'hFF00, 16'h0100, 16'h0000, 0);
      check("pin_reset_code", {err, word}, {1'b0, 8'h80});
      run_decode(16'hFFFC, 16'h0004, 16'h001F, 0);
      check("pin_even_25", {err, word}, {1'b0, 8'h25});
      run_decode(16'hFFF8, 16'h0008, 16'hFE00, 0);
      check("pin_odd_37", {err, word}, {1'b0, 8'h37});

      for (int v = 0; v < 256; v++) begin
         encode(v, a, b, c);
         run_decode(a, b, c, 0);
      end
      check("sweep_err_cnt", err_cnt, 0);
      check("sweep_last_word", word, 8'hFF);

      // Illegal patterns, each followed by a legal one.
      run_decode(16'hFFF8, 16'h0010, 16'h0000, 0);
      check("held_row_mismatch", {err, word}, {1'b1, 8'hFF});
      run_decode(16'hFFFC, 16'h0004, 16'h001F, 0);
      run_decode(16'hFFF8, 16'h0008, 16'h007F, 0);
      check("held_col_dir", {err, word}, {1'b1, 8'h25});
      run_decode(16'hFFF8, 16'h0008, 16'hFE00, 0);
      run_decode(16'hFFFF, 16'h0001, 16'hFFFF, 0);
      check("held_col_full", {err, word}, {1'b1, 8'h37});
      run_decode(16'hFFFC, 16'h0004, 16'h001F, 0);
      run_decode(16'hFF0E, 16'h0008, 16'h0000, 0);
      check("held_non_therm", {err, word}, {1'b1, 8'h25});
      run_decode(16'hFFF8, 16'h0008, 16'hFE00, 0);
      check("legal_after_err", err, 0);
      run_decode(16'h0000, 16'h0000, 16'h0000, 0);
      check("err_cnt_five", err_cnt, 5);
      check("err_cnt2_sat", err_cnt2, 3);

      // Inputs changed right after the start edge must not matter.
      encode(8'h9A, a, b, c);
      run_decode(a, b, c, 1);
      check("pin_scramble_9a", {err, word}, {1'b0, 8'h9A});

      // en held high: starts at k, k+18, k+36.
      encode(8'h6C, a, b, c);
      @(negedge clk);
      r_all = a;
      row   = b;
      col   = c;
      en    = 1'b1;
      @(posedge clk);
      #1;
      k = cyc;
      ref_decode(a, b, c, ok, w);
      for (int j = 0; j < 3; j++) push_exp(ok, w, k + 17 + 18 * j);
      while (cyc < k + 36) begin
         @(posedge clk);
         #1;
      end
      en = 1'b0;
      drain();
      check("pin_held_en_6c", word, 8'h6C);

      // Reset at scan cycle 7 aborts with no later valid.
      encode(8'h41, a, b, c);
      @(negedge clk);
      r_all = a;
      row   = b;
      col   = c;
      en    = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b0;
      repeat (7) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_valid", valid, 0);
      check("abort_word", word, 8'h80);
      check("abort_err_cnt", err_cnt, 0);
      m_word = 8'h80;
      m_err  = 1'b0;
      m_cnt  = '0;
      m_cnt2 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);

      run_decode(16'hFFFC, 16'h0004, 16'h001F, 0);
      check("pin_recover_25", {err, word, err_cnt}, {1'b0, 8'h25, 8'h00});

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/row_col_dec.md
# row_col_dec

Inverse of the DCO capacitor-bank row/column coder. It takes the bank's three select vectors: `r_all` (zero-active row thermometer), `row` (one-hot) and `col` (serpentine column thermometer). It reconstructs the binary tuning word and flags any illegal select pattern. It sits beside the DCO model as a consistency monitor and readback path. A bit-serial scan FSM checks one row/column index per cycle to keep area small.

## Interface
- `WORD_W`, 8, tuning word width; must equal 2*`ROW_W`.
- `ROW_W`, 4, log2 of rows (= log2 of columns).
- `SIZE`, 1<<`ROW_W`, rows = columns = vector width.
- `CNT_W`, 8, error counter width.

- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset; asynchronous and active-low (0 = reset).
- `en`  in  1  start request; sampled only in IDLE.
- `r_all`  in  SIZE  row-all vector; bit i = 0 for rows fully on.
- `row`  in  SIZE  one-hot partial-row select.
- `col`  in  SIZE  column thermometer of the partial row.
- `busy`  out  1  scan in progress.
- `valid`  out  1  one-cycle pulse; `word` and `err` are updated.
- `word`  out  WORD_W  decoded tuning word.
- `err`  out  1  last decode was illegal.
- `err_cnt`  out  CNT_W  saturating count of illegal decodes.

## Operation
- Legal code for word W: R = W>>ROW_W and C = W[ROW_W-1:0].
  - `r_all[i]` = 0 for i<R, 1 for i≥R.
  - `row` = 1<<R.
  - R even: `col[i]` = 1 for i<C.
  - R odd: `col[i]` = 1 for i≥SIZE-C.
  - Everything else is illegal.
- States are IDLE, SCAN, DONE.
- IDLE, `en`=1:
  - Copy `r_all`, `row` and `col` into shadow registers.
  - Clear `idx` and all scan flags/counters; go to SCAN.
  - Inputs may change afterwards without effect.
- SCAN, bit `idx` of each shadow vector per cycle:
  - r_all: zcnt += ~bit. Set therm_bad if bit = 0 after a 1 was seen at a lower index.
  - row: on a 1, rcnt += 1 (saturate at 2) and ridx = `idx`.
  - col: ccnt += bit. Set rise if col[idx]=1 and col[idx-1]=0 (idx>0). Set fall if col[idx]=0 and col[idx-1]=1.
  - `idx` == SIZE-1: go to DONE.
- DONE evaluates in one cycle with R = zcnt and C = ccnt. err = 1 if any of:
  - therm_bad, or R = SIZE;
  - rcnt ≠ 1, or ridx ≠ R;
  - C = SIZE;
  - R even and rise set;
  - R odd and fall set.
- err=0: `word` ← R*SIZE + C.
- err=1: `word` holds its previous value; `err_cnt` += 1, saturating at all-ones.
- `err` is always updated; pulse `valid`; return to IDLE.
- Arithmetic: zcnt, ccnt and ridx are `ROW_W`+1 bits wide so they can represent SIZE; `word` is the low `WORD_W` bits.

## Timing
- Reset values (async, while `rst`=0):
  - state IDLE; `busy`=0, `valid`=0, `err`=0;
  - `word` = 1<<(`WORD_W`-1) (0x80, the bank's half-on reset code); `err_cnt`=0.
- Start edge k (IDLE, `en`=1):
  - `busy`=1 after edge k;
  - edges k+1..k+SIZE scan bits 0..SIZE-1;
  - edge k+SIZE+1 executes DONE: `word`/`err` update, `valid`=1 for one cycle, `busy`=0.
- Latency from the start edge to `valid` is SIZE+1 clocks (17 at default).
- The next `en` is accepted at edge k+SIZE+2, so back-to-back throughput is one decode per SIZE+2 clocks.
- `en` while busy or in DONE is ignored, not queued.
- `rst` asserted mid-scan aborts at once; all outputs take reset values and the partial scan is discarded.
- `word`, `err` and `err_cnt` change only on a DONE edge or on reset.

## Test plan
- Reset-state code: `r_all`=0xFF00, `row`=0x0100, `col`=0x0000, `en` pulse -> `valid` 17 clocks later, `word`=0x80, `err`=0.
- Even row, W=0x25: `r_all`=0xFFFC, `row`=0x0004, `col`=0x001F -> `word`=0x25, `err`=0. Also sweep all 256 words from a reference coder model -> zero mismatches, `err_cnt`=0.
- Odd row, W=0x37: `r_all`=0xFFF8, `row`=0x0008, `col`=0xFE00 -> `word`=0x37, `err`=0.
- Illegal codes, each followed by a legal one:
  - row mismatch: `row`=0x0010 with `r_all`=0xFFF8;
  - wrong column direction: R=3 with `col`=0x007F;
  - `col`=0xFFFF;
  - non-thermometer `r_all`=0xFF0E.
  - Required: each gives `err`=1, `word` held, `err_cnt` +1.
  - With `CNT_W` overridden to 2, five errors leave `err_cnt`=3.
- Handshake:
  - `en` held high continuously -> decodes start every 18 clocks.
  - Changing inputs right after the start edge does not alter the result.
  - `rst` low at scan cycle 7 -> `busy`=0, `valid`=0, `word`=0x80, `err_cnt`=0 immediately, with no later `valid`.
